// File: rtl/sweep_pattern_gen.sv
// sweep_pattern_gen: WIDTH-bit bounce/rotate/fill-bar mask stepped by a prescaled tick edge.
// Define SWEEP_PATTERN_SYNC_EN to pass tick_i and en_i through 2-flop synchronisers.
module sweep_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int TAIL  = 1,
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [WIDTH-1:0] mask_o,
    output logic             dir_o,
    output logic             limit_o
);
    localparam int PW = $clog2(WIDTH) + 1;
    localparam logic [PW-1:0] PMAX = PW'(WIDTH - TAIL);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    localparam logic [1:0] BNC = 2'd0, RUP = 2'd1, RDN = 2'd2, FILL = 2'd3;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    pos, pos_n;
    logic             dir_n, lim_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [1:0]       mode_q, mode_n;
    logic [WIDTH-1:0] mask_n;
    logic             tick_s, en_s, tick_q, tick_rise;

`ifdef SWEEP_PATTERN_SYNC_EN
    logic [1:0] tick_sync, en_sync;
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tick_sync <= '0;
            en_sync   <= '0;
        end else begin
            tick_sync <= {tick_sync[0], tick_i};
            en_sync   <= {en_sync[0], en_i};
        end
    end
    assign tick_s = tick_sync[1];
    assign en_s   = en_sync[1];
`else
    assign tick_s = tick_i;
    assign en_s   = en_i;
`endif

    assign tick_rise = tick_s & ~tick_q;

    function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m, input logic [PW-1:0] p);
        logic [PW-1:0] d;
        pattern = '0;
        for (int i = 0; i < WIDTH; i++) begin
            d = (PW'(i) >= p) ? PW'(i) - p : PW'(i) + PW'(WIDTH) - p;
            pattern[i] = (m == FILL) ? (PW'(i) <= p) : (d < PW'(TAIL));
        end
    endfunction

    always_comb begin
        state_n = state;
        pos_n   = pos;
        dir_n   = dir_o;
        cnt_n   = cnt;
        mode_n  = mode_q;
        mask_n  = mask_o;
        lim_n   = 1'b0;
        if (!en_s) begin
            state_n = IDLE;
            mask_n  = '0;
            dir_n   = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mask_n  = '0;
                    state_n = LOAD;
                end
                LOAD: begin
                    pos_n   = '0;
                    dir_n   = (mode_i == RDN);
                    cnt_n   = '0;
                    mode_n  = mode_i;
                    mask_n  = pattern(mode_i, '0);
                    state_n = RUN;
                end
                default: begin
                    if (mode_i != mode_q) begin
                        state_n = LOAD;
                    end else if (tick_rise) begin
                        cnt_n = (cnt >= div_i) ? '0 : cnt + 1'b1;
                        if (cnt >= div_i) begin
                            unique case (mode_q)
                                BNC: begin
                                    if (PMAX == '0) begin
                                        lim_n = 1'b1;
                                    end else begin
                                        pos_n = dir_o ? pos - 1'b1 : pos + 1'b1;
                                        lim_n = dir_o ? (pos_n == '0) : (pos_n == PMAX);
                                    end
                                    dir_n = dir_o ^ lim_n;
                                end
                                RDN: begin
                                    lim_n = (pos == '0);
                                    pos_n = lim_n ? LAST : pos - 1'b1;
                                    dir_n = 1'b1;
                                end
                                default: begin
                                    lim_n = (pos == LAST);
                                    pos_n = lim_n ? '0 : pos + 1'b1;
                                    dir_n = 1'b0;
                                end
                            endcase
                            mask_n = pattern(mode_q, pos_n);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state   <= IDLE;
            pos     <= '0;
            dir_o   <= 1'b0;
            cnt     <= '0;
            mode_q  <= BNC;
            mask_o  <= '0;
            limit_o <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_n;
            pos     <= pos_n;
            dir_o   <= dir_n;
            cnt     <= cnt_n;
            mode_q  <= mode_n;
            mask_o  <= mask_n;
            limit_o <= lim_n;
            tick_q  <= tick_s;
        end
    end
endmodule

// File: tb/tb_sweep_pattern_gen.sv
// tb_sweep_pattern_gen: directed bench driving TAIL=1/2/3 instances of sweep_pattern_gen in parallel.
module tb_sweep_pattern_gen;
    logic       clk_i = 1'b0;
    logic       arstn_i, en_i, tick_i;
    logic [1:0] mode_i;
    logic [3:0] div_i;
    logic [7:0] m1, m2, m3;
    logic       d1, d2, d3, l1, l2, l3;
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sweep_pattern_gen #(.WIDTH(8), .TAIL(1), .DIV_W(4)) u_t1 (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i), .tick_i(tick_i),
        .mode_i(mode_i), .div_i(div_i), .mask_o(m1), .dir_o(d1), .limit_o(l1));
    sweep_pattern_gen #(.WIDTH(8), .TAIL(2), .DIV_W(4)) u_t2 (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i), .tick_i(tick_i),
        .mode_i(mode_i), .div_i(div_i), .mask_o(m2), .dir_o(d2), .limit_o(l2));
    sweep_pattern_gen #(.WIDTH(8), .TAIL(3), .DIV_W(4)) u_t3 (
        .clk_i(clk_i), .arstn_i(arstn_i), .en_i(en_i), .tick_i(tick_i),
        .mode_i(mode_i), .div_i(div_i), .mask_o(m3), .dir_o(d3), .limit_o(l3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk_i);
        tick_i = 1'b1;
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    logic [7:0] bnc_exp [8] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60, 8'h30};
    logic       bnc_dir [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] rup_exp [8] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
    logic [7:0] fill_exp;

    initial begin
        arstn_i = 1'b0; en_i = 1'b0; tick_i = 1'b0; mode_i = 2'b00; div_i = 4'd0;
        repeat (2) @(negedge clk_i);
        chk("reset_mask", 32'(m2), 32'h00);
        chk("reset_dir", 32'(d2), 32'h0);
        chk("reset_limit", 32'(l2), 32'h0);
        arstn_i = 1'b1; en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("init_t1", 32'(m1), 32'h01);
        chk("init_t2", 32'(m2), 32'h03);
        chk("init_t3", 32'(m3), 32'h07);
        for (int k = 0; k < 8; k++) begin
            pulse();
            chk($sformatf("bounce_mask_%0d", k), 32'(m2), 32'(bnc_exp[k]));
            chk($sformatf("bounce_limit_%0d", k), 32'(l2), 32'(k == 5));
            chk($sformatf("bounce_dir_%0d", k), 32'(d2), 32'(bnc_dir[k]));
        end
        mode_i = 2'b01;
        repeat (2) @(negedge clk_i);
        chk("rup_init", 32'(m3), 32'h07);
        for (int k = 0; k < 8; k++) begin
            pulse();
            chk($sformatf("rup_mask_%0d", k), 32'(m3), 32'(rup_exp[k]));
            chk($sformatf("rup_limit_%0d", k), 32'(l3), 32'(k == 7));
            chk($sformatf("rup_dir_%0d", k), 32'(d3), 32'h0);
        end
        mode_i = 2'b11; div_i = 4'd2;
        repeat (2) @(negedge clk_i);
        chk("fill_init", 32'(m1), 32'h01);
        for (int k = 1; k <= 24; k++) begin
            pulse();
            fill_exp = 8'((9'd2 << ((k / 3) % 8)) - 9'd1);
            chk($sformatf("fill_mask_%0d", k), 32'(m1), 32'(fill_exp));
            chk($sformatf("fill_limit_%0d", k), 32'(l1), 32'(k == 24));
        end
        mode_i = 2'b00; div_i = 4'd0;
        repeat (2) @(negedge clk_i);
        chk("bnc_t1_init", 32'(m1), 32'h01);
        pulse();
        chk("bnc_t1_step", 32'(m1), 32'h02);
        @(negedge clk_i);
        mode_i = 2'b10; tick_i = 1'b1;
        @(negedge clk_i);
        tick_i = 1'b0;
        chk("mode_chg_drop", 32'(m1), 32'h02);
        @(negedge clk_i);
        chk("mode_chg_load", 32'(m1), 32'h01);
        pulse();
        chk("rdn_wrap_mask", 32'(m1), 32'h80);
        chk("rdn_wrap_limit", 32'(l1), 32'h1);
        chk("rdn_wrap_dir", 32'(d1), 32'h1);
        @(negedge clk_i);
        tick_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("held_tick_mask", 32'(m1), 32'h40);
        chk("held_tick_limit", 32'(l1), 32'h0);
        tick_i = 1'b0; div_i = 4'd1; en_i = 1'b0;
        @(negedge clk_i);
        chk("en_off_mask", 32'(m1), 32'h00);
        chk("en_off_dir", 32'(d1), 32'h0);
        en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("en_restart", 32'(m1), 32'h01);
        pulse();
        chk("div1_hold", 32'(m1), 32'h01);
        pulse();
        chk("div1_step", 32'(m1), 32'h80);
        chk("div1_limit", 32'(l1), 32'h1);
        mode_i = 2'b00; div_i = 4'd0;
        repeat (2) @(negedge clk_i);
        chk("pre_rst_init", 32'(m1), 32'h01);
        repeat (4) pulse();
        chk("pre_rst_mask", 32'(m1), 32'h10);
        #2 arstn_i = 1'b0;
        #1;
        chk("async_rst_mask", 32'(m1), 32'h00);
        chk("async_rst_dir", 32'(d1), 32'h0);
        chk("async_rst_limit", 32'(l1), 32'h0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_mask", 32'(m1), 32'h01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
